stopwatch_counter: RTL and testbench

Free-running stopwatch time base for the display path. It divides the system clock into centisecond ticks and keeps elapsed time as packed BCD centiseconds, seconds and minutes under start/stop and clear control. It sits directly upstream of the display scan chooser. The chooser consumes `out_ms`, `out_s` and `out_min` as its `in_ms`, `in_s` and `in_min` buses.

---
 rtl/stopwatch_counter_if.sv | 34 +++
 rtl/stopwatch_counter.sv | 166 ++++++++++++++++
 tb/tb_stopwatch_counter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_counter_if.sv
// Control and display bus of the stopwatch time base.
// The lap input exists only when STOPWATCH_LAP_EN is defined.
interface stopwatch_counter_if;
  logic       start_stop;
  logic       clear;
`ifdef STOPWATCH_LAP_EN
  logic       lap;
`endif
  logic [7:0] out_ms;
  logic [7:0] out_s;
  logic [7:0] out_min;
  logic       running;
  logic       wrap;

`ifdef STOPWATCH_LAP_EN
  modport master (
    output start_stop, clear, lap,
    input  out_ms, out_s, out_min, running, wrap
  );
  modport slave (
    input  start_stop, clear, lap,
    output out_ms, out_s, out_min, running, wrap
  );
`else
  modport master (
    output start_stop, clear,
    input  out_ms, out_s, out_min, running, wrap
  );
  modport slave (
    input  start_stop, clear,
    output out_ms, out_s, out_min, running, wrap
  );
`endif
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch time base: centisecond prescaler feeding a BCD mm:ss.cc cascade with start/stop/clear control.
// Define STOPWATCH_LAP_EN to add the lap input that freezes the displayed time while counting continues.
module stopwatch_counter #(
  parameter int unsigned TICK_DIV = 500000
) (
  input logic                clk,
  input logic                rst,
  stopwatch_counter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  localparam logic [23:0] PRESC_LAST = 24'(TICK_DIV - 1);

  state_t      state, state_nxt;
  logic        ss_q, clr_q, ss_ev, clr_ev;
  logic [23:0] presc, presc_nxt;
  logic [7:0]  cnt_ms, cnt_s, cnt_min;
  logic [7:0]  ms_nxt, s_nxt, min_nxt;
  logic        c_ms, c_s, c_min;
  logic        tick, zero_all;
  logic        wrap_pend, wrap_pend_nxt;
  logic        load_out;

  // Returns {carry, tens, units}; units roll 9->0, tens roll tens_max->0.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [3:0] tens_max);
    logic [3:0] u, t;
    logic       c;
    u = v[3:0];
    t = v[7:4];
    c = 1'b0;
    if (u != 4'd9) begin
      u = u + 4'd1;
    end else begin
      u = '0;
      if (t != tens_max) begin
        t = t + 4'd1;
      end else begin
        t = '0;
        c = 1'b1;
      end
    end
    return {c, t, u};
  endfunction

  // Edge pulses are registered, so the FSM acts one clock after the input is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q   <= 1'b0;
      clr_q  <= 1'b0;
      ss_ev  <= 1'b0;
      clr_ev <= 1'b0;
    end else begin
      ss_q   <= bus.start_stop;
      clr_q  <= bus.clear;
      ss_ev  <= bus.start_stop & ~ss_q;
      clr_ev <= bus.clear & ~clr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_ev) state_nxt = RUN;
      RUN:     if (ss_ev) state_nxt = PAUSE;
      PAUSE:   if (ss_ev) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (clr_ev) state_nxt = IDLE;
  end

  assign tick     = (state == RUN) && (presc == PRESC_LAST);
  assign zero_all = clr_ev || (state == ILLEGAL);

  always_comb begin
    presc_nxt     = presc;
    ms_nxt        = cnt_ms;
    s_nxt         = cnt_s;
    min_nxt       = cnt_min;
    c_ms          = 1'b0;
    c_s           = 1'b0;
    c_min         = 1'b0;
    wrap_pend_nxt = 1'b0;
    if (zero_all) begin
      presc_nxt = '0;
      ms_nxt    = '0;
      s_nxt     = '0;
      min_nxt   = '0;
    end else if (state == RUN) begin
      presc_nxt = tick ? '0 : presc + 24'd1;
      if (tick) begin
        {c_ms, ms_nxt} = bcd_inc(cnt_ms, 4'd9);
        if (c_ms) {c_s, s_nxt} = bcd_inc(cnt_s, 4'd5);
        if (c_s) {c_min, min_nxt} = bcd_inc(cnt_min, 4'd5);
        wrap_pend_nxt = c_min;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      cnt_ms    <= '0;
      cnt_s     <= '0;
      cnt_min   <= '0;
      wrap_pend <= 1'b0;
    end else begin
      presc     <= presc_nxt;
      cnt_ms    <= ms_nxt;
      cnt_s     <= s_nxt;
      cnt_min   <= min_nxt;
      wrap_pend <= wrap_pend_nxt;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_q, lap_ev, frz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q  <= 1'b0;
      lap_ev <= 1'b0;
      frz    <= 1'b0;
    end else begin
      lap_q  <= bus.lap;
      lap_ev <= bus.lap & ~lap_q;
      if (zero_all)
        frz <= 1'b0;
      else if (lap_ev && (state == RUN || state == PAUSE))
        frz <= ~frz;
    end
  end

  assign load_out = ~frz;
`else
  assign load_out = 1'b1;
`endif

  // wrap is delayed with the outputs so it coincides with the 00:00.00 display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_ms  <= '0;
      bus.out_s   <= '0;
      bus.out_min <= '0;
      bus.running <= 1'b0;
      bus.wrap    <= 1'b0;
    end else begin
      bus.running <= (state == RUN);
      bus.wrap    <= wrap_pend;
      if (load_out) begin
        bus.out_ms  <= cnt_ms;
        bus.out_s   <= cnt_s;
        bus.out_min <= cnt_min;
      end
    end
  end
endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter (TICK_DIV=4): vector table, corner sequences and a random run
// against a centisecond-count reference model. Lap checks are built with STOPWATCH_LAP_EN.
module tb_stopwatch_counter;
  localparam int TDIV = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lap_drv = 1'b0;
  bit   pl_en = 1'b0;
  int   pl_val = 0;
  bit   chk_on = 1'b0;
  int   checks = 0;
  int   errors = 0;

  stopwatch_counter_if bus ();
`ifdef STOPWATCH_LAP_EN
  assign bus.lap = lap_drv;
`endif

  stopwatch_counter #(.TICK_DIV(TDIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: elapsed time is one integer of centiseconds; digits derived by division.
  typedef struct packed {
    bit ss_q; bit clr_q; bit lap_q;
    bit ss_ev; bit clr_ev; bit lap_ev;
    int mode;
    int presc;
    int cs;
    bit frz;
    int disp;
    bit run_o; bit wrap_pend; bit wrap_o;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(mstate_t c, bit ss, bit clr, bit lp, bit pl, int plv);
    mstate_t n;
    int cur;
    bit tk;
    n = c;
    cur = pl ? plv : c.cs;
    n.ss_q = ss; n.clr_q = clr; n.lap_q = lp;
    n.ss_ev = ss && !c.ss_q;
    n.clr_ev = clr && !c.clr_q;
    n.lap_ev = lp && !c.lap_q;
    n.run_o = (c.mode == 1);
    n.wrap_o = c.wrap_pend;
    n.disp = c.frz ? c.disp : cur;
    n.cs = cur;
    n.wrap_pend = 1'b0;
    tk = (c.mode == 1) && (c.presc == TDIV - 1);
    if (c.clr_ev) begin
      n.mode = 0; n.cs = 0; n.presc = 0; n.frz = 1'b0;
    end else begin
      if (c.mode == 1) begin
        n.presc = (c.presc + 1) % TDIV;
        if (tk) begin
          n.cs = (cur + 1) % 360000;
          n.wrap_pend = (cur == 359999);
        end
      end
      if (c.ss_ev) n.mode = (c.mode == 1) ? 2 : 1;
      if (LAP_EN && c.lap_ev && c.mode != 0) n.frz = !c.frz;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_next(m, bus.start_stop, bus.clear, lap_drv, pl_en, pl_val);
  end

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_time(input string name, input logic [7:0] mn, input logic [7:0] s,
                          input logic [7:0] ms);
    chk({name, " min"}, 32'(bus.out_min), 32'(mn));
    chk({name, " s"},   32'(bus.out_s),   32'(s));
    chk({name, " ms"},  32'(bus.out_ms),  32'(ms));
  endtask

  task automatic wait_time(input string name, input logic [7:0] mn, input logic [7:0] s,
                           input logic [7:0] ms, input int limit);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      if (bus.out_min == mn && bus.out_s == s && bus.out_ms == ms) hit = 1'b1;
    end
    chk({name, " reached"}, 32'(hit), 32'd1);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model min", 32'(bus.out_min), 32'(to_bcd(m.disp / 6000)));
      chk("model s",   32'(bus.out_s),   32'(to_bcd((m.disp / 100) % 60)));
      chk("model ms",  32'(bus.out_ms),  32'(to_bcd(m.disp % 100)));
      chk("model running", 32'(bus.running), 32'(m.run_o));
      chk("model wrap",    32'(bus.wrap),    32'(m.wrap_o));
    end
  end

  typedef struct {
    bit          ss;
    bit          clr;
    int unsigned cyc;
    logic [7:0]  mn, s, ms;
    bit          run;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int wraps;
    bit saw99;

    tbl[0] = '{0, 0, 100, 8'h00, 8'h00, 8'h00, 0};
    tbl[1] = '{1, 0,   3, 8'h00, 8'h00, 8'h00, 1};
    tbl[2] = '{1, 0,   4, 8'h00, 8'h00, 8'h01, 1};
    tbl[3] = '{0, 0, 400, 8'h00, 8'h01, 8'h01, 1};
    tbl[4] = '{1, 0,   5, 8'h00, 8'h01, 8'h01, 0};
    tbl[5] = '{0, 0,  50, 8'h00, 8'h01, 8'h01, 0};
    tbl[6] = '{1, 0,   4, 8'h00, 8'h01, 8'h02, 1};
    tbl[7] = '{0, 1,   3, 8'h00, 8'h00, 8'h00, 0};
    tbl[8] = '{0, 0,  20, 8'h00, 8'h00, 8'h00, 0};

    bus.start_stop = 1'b0;
    bus.clear = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_time("reset", 8'h00, 8'h00, 8'h00);
    chk("reset running", 32'(bus.running), 32'd0);
    chk("reset wrap", 32'(bus.wrap), 32'd0);
    rst = 1'b0;
    chk_on = 1'b1;

    foreach (tbl[i]) begin
      bus.start_stop = tbl[i].ss;
      bus.clear = tbl[i].clr;
      repeat (tbl[i].cyc) @(negedge clk);
      chk_time($sformatf("vec%0d", i), tbl[i].mn, tbl[i].s, tbl[i].ms);
      chk($sformatf("vec%0d running", i), 32'(bus.running), 32'(tbl[i].run));
    end

    // Simultaneous clear and start_stop while running: clear wins.
    bus.start_stop = 1'b1;
    repeat (2) @(negedge clk);
    bus.start_stop = 1'b0;
    wait_time("to 12.34", 8'h00, 8'h12, 8'h34, 6000);
    bus.start_stop = 1'b1;
    bus.clear = 1'b1;
    repeat (3) @(negedge clk);
    chk_time("clr+ss", 8'h00, 8'h00, 8'h00);
    chk("clr+ss running", 32'(bus.running), 32'd0);
    bus.start_stop = 1'b0;
    bus.clear = 1'b0;
    repeat (10) @(negedge clk);
    chk_time("clr+ss idle", 8'h00, 8'h00, 8'h00);
    chk("clr+ss idle running", 32'(bus.running), 32'd0);

    // Preload 59:59.98 while paused, then resume through the rollover.
    bus.start_stop = 1'b1;
    repeat (2) @(negedge clk);
    bus.start_stop = 1'b0;
    repeat (10) @(negedge clk);
    bus.start_stop = 1'b1;
    repeat (2) @(negedge clk);
    bus.start_stop = 1'b0;
    repeat (3) @(negedge clk);
    force dut.cnt_ms = 8'h98;
    force dut.cnt_s = 8'h59;
    force dut.cnt_min = 8'h59;
    pl_val = 359998;
    pl_en = 1'b1;
    @(negedge clk);
    release dut.cnt_ms;
    release dut.cnt_s;
    release dut.cnt_min;
    pl_en = 1'b0;
    repeat (2) @(negedge clk);
    chk_time("preload", 8'h59, 8'h59, 8'h98);
    bus.start_stop = 1'b1;
    repeat (2) @(negedge clk);
    bus.start_stop = 1'b0;
    wraps = 0;
    saw99 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_min == 8'h59 && bus.out_s == 8'h59 && bus.out_ms == 8'h99) saw99 = 1'b1;
      if (bus.wrap) begin
        wraps++;
        chk_time("wrap value", 8'h00, 8'h00, 8'h00);
      end
    end
    chk("saw 59:59.99", 32'(saw99), 32'd1);
    chk("wrap pulse count", 32'(wraps), 32'd1);
    bus.clear = 1'b1;
    repeat (2) @(negedge clk);
    bus.clear = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a count.
    bus.start_stop = 1'b1;
    repeat (2) @(negedge clk);
    bus.start_stop = 1'b0;
    wait_time("to 05.07", 8'h00, 8'h05, 8'h07, 3000);
    #2 rst = 1'b1;
    #1;
    chk_time("async rst", 8'h00, 8'h00, 8'h00);
    chk("async rst running", 32'(bus.running), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk_time("after rst", 8'h00, 8'h00, 8'h00);
    chk("after rst running", 32'(bus.running), 32'd0);

`ifdef STOPWATCH_LAP_EN
    // Freeze at 00:01.00; the count keeps going underneath.
    bus.start_stop = 1'b1;
    repeat (2) @(negedge clk);
    bus.start_stop = 1'b0;
    wait_time("to 01.00", 8'h00, 8'h01, 8'h00, 1000);
    lap_drv = 1'b1;
    repeat (2) @(negedge clk);
    lap_drv = 1'b0;
    for (int i = 0; i < 38; i++) begin
      @(negedge clk);
      chk_time("frozen", 8'h00, 8'h01, 8'h00);
    end
    lap_drv = 1'b1;
    repeat (3) @(negedge clk);
    chk_time("unfrozen", 8'h00, 8'h01, 8'h10);
    lap_drv = 1'b0;
    bus.clear = 1'b1;
    repeat (2) @(negedge clk);
    bus.clear = 1'b0;
`endif

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(23, 0) == 0) bus.start_stop = ~bus.start_stop;
      if (bus.clear) bus.clear = 1'b0;
      else if ($urandom_range(299, 0) == 0) bus.clear = 1'b1;
      if ($urandom_range(19, 0) == 0) lap_drv = ~lap_drv;
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
